// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard unit: a shift-register scoreboard of in-flight
// register writes (EX..WB) that stalls decode and bubbles EX on a pending source.
module hazard_scoreboard #(
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned RF_BYPASS = 1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             is_reg1_valid,
    input  logic             is_reg2_valid,
    input  logic             dest_reg_write,
    input  logic             dest_reg_sel,
    input  logic [1:0]       jump,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    input  logic             ex_stall,
    input  logic             flush,
    output logic             hazard,
    output logic             id_hold,
    output logic             ex_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count
);

    // The WB entry is excluded when the register file writes before it reads.
    localparam int unsigned MATCH_N  = DEPTH - RF_BYPASS;
    localparam logic [1:0]  JUMP_JAL = 2'b10;

    logic [DEPTH-1:0]      v_q, v_d;
    logic [DEPTH-1:0][4:0] dst_q, dst_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic       is_jal;
    logic       wr_id;
    logic       match;
    logic [4:0] dst_id;
    logic       unused_wb_dst;

    always_comb begin
        is_jal = (jump == JUMP_JAL);
        dst_id = is_jal ? 5'd31 : (dest_reg_sel ? rd : rt);
        wr_id  = id_valid & (dest_reg_write | is_jal) & (dst_id != '0);

        match = 1'b0;
        for (int unsigned i = 0; i < MATCH_N; i++) begin
            if (v_q[i] &&
                ((is_reg1_valid && rs == dst_q[i] && rs != '0) ||
                 (is_reg2_valid && rt == dst_q[i] && rt != '0))) begin
                match = 1'b1;
            end
        end

        // A flushed instruction never stalls, so flush wins over a match.
        hazard    = id_valid & ~flush & match;
        id_hold   = hazard | ex_stall;
        ex_bubble = ~ex_stall & (hazard | flush | ~id_valid);
        busy      = |v_q;
    end

    always_comb begin
        v_d   = v_q;
        dst_d = dst_q;
        cnt_d = cnt_q;
        if (!ex_stall) begin
            for (int unsigned i = DEPTH - 1; i > 0; i--) begin
                v_d[i]   = v_q[i-1];
                dst_d[i] = dst_q[i-1];
            end
            v_d[0]   = wr_id & ~hazard & ~flush;
            dst_d[0] = dst_id;
            if (hazard) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // The retiring entry's destination only feeds matching when there is no bypass.
    always_comb unused_wb_dst = ^dst_q[DEPTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q   <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            dst_q <= dst_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default instance plus a no-bypass
// instance sharing the same stimulus.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic        is_reg1_valid = 1'b0;
    logic        is_reg2_valid = 1'b0;
    logic        dest_reg_write = 1'b0;
    logic        dest_reg_sel = 1'b0;
    logic [1:0]  jump = 2'b00;
    logic [4:0]  rs = '0;
    logic [4:0]  rt = '0;
    logic [4:0]  rd = '0;
    logic        ex_stall = 1'b0;
    logic        flush = 1'b0;

    logic        hazard, id_hold, ex_bubble, busy;
    logic [31:0] stall_count;
    logic        hazard0, id_hold0, ex_bubble0, busy0;
    logic [31:0] stall_count0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(3), .RF_BYPASS(1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .is_reg1_valid(is_reg1_valid), .is_reg2_valid(is_reg2_valid),
        .dest_reg_write(dest_reg_write), .dest_reg_sel(dest_reg_sel),
        .jump(jump), .rs(rs), .rt(rt), .rd(rd),
        .ex_stall(ex_stall), .flush(flush),
        .hazard(hazard), .id_hold(id_hold), .ex_bubble(ex_bubble),
        .busy(busy), .stall_count(stall_count)
    );

    hazard_scoreboard #(.DEPTH(3), .RF_BYPASS(0), .CNT_W(32)) dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .is_reg1_valid(is_reg1_valid), .is_reg2_valid(is_reg2_valid),
        .dest_reg_write(dest_reg_write), .dest_reg_sel(dest_reg_sel),
        .jump(jump), .rs(rs), .rt(rt), .rd(rd),
        .ex_stall(ex_stall), .flush(flush),
        .hazard(hazard0), .id_hold(id_hold0), .ex_bubble(ex_bubble0),
        .busy(busy0), .stall_count(stall_count0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // v r1 r2 wr sel jump rs rt rd; settles before returning
    task automatic set_in(input logic v, input logic r1, input logic r2,
                          input logic wr, input logic sel, input logic [1:0] j,
                          input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        id_valid = v; is_reg1_valid = r1; is_reg2_valid = r2;
        dest_reg_write = wr; dest_reg_sel = sel; jump = j;
        rs = s; rt = t; rd = d;
        #1;
    endtask

    task automatic do_reset;
        ex_stall = 1'b0; flush = 1'b0;
        set_in(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;

        // Reset state, with a real non-reading, non-writing instruction in decode
        set_in(1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        check("rst_hazard", hazard, 0);
        check("rst_id_hold", id_hold, 0);
        check("rst_ex_bubble", ex_bubble, 0);
        check("rst_busy", busy, 0);
        check("rst_count", stall_count, 0);
        check("rst_busy0", busy0, 0);
        tick();

        // ADDI $1,$0,5 then ADD $2,$1,$1
        set_in(1, 1, 0, 1, 0, 2'b00, 0, 1, 0);
        check("addi_hazard", hazard, 0);
        tick();
        set_in(1, 1, 1, 1, 1, 2'b00, 1, 1, 2);
        check("raw_c1_hazard", hazard, 1);
        check("raw_c1_bubble", ex_bubble, 1);
        check("raw_c1_hold", id_hold, 1);
        check("raw_c1_hold0", id_hold0, 1);
        check("raw_c1_bubble0", ex_bubble0, 1);
        tick();
        check("raw_c2_hazard", hazard, 1);
        check("raw_c2_bubble", ex_bubble, 1);
        tick();
        check("raw_c3_hazard", hazard, 0);
        check("raw_c3_bubble", ex_bubble, 0);
        check("raw_count", stall_count, 2);
        check("nobyp_c3_hazard", hazard0, 1);
        check("nobyp_c3_count", stall_count0, 2);
        tick();
        check("nobyp_c4_hazard", hazard0, 0);
        check("nobyp_count", stall_count0, 3);

        // ADDI $0 then ADD $3,$0,$0: writes to $0 never tracked
        do_reset();
        set_in(1, 1, 0, 1, 0, 2'b00, 0, 0, 0);
        check("r0_w_hazard", hazard, 0);
        check("r0_w_busy", busy, 0);
        tick();
        set_in(1, 1, 1, 1, 1, 2'b00, 0, 0, 3);
        check("r0_r_hazard", hazard, 0);
        check("r0_r_busy", busy, 0);
        tick();

        // JAL then JR $31 (rd=0, so JR inserts nothing)
        do_reset();
        set_in(1, 0, 0, 0, 0, 2'b10, 0, 0, 0);
        check("jal_hazard", hazard, 0);
        tick();
        set_in(1, 1, 0, 1, 1, 2'b00, 31, 0, 0);
        check("jr_c1_hazard", hazard, 1);
        tick();
        check("jr_c2_hazard", hazard, 1);
        tick();
        check("jr_c3_hazard", hazard, 0);
        check("jr_count", stall_count, 2);
        tick();
        set_in(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        check("jr_no_entry_busy", busy, 0);
        check("jr_idle_bubble", ex_bubble, 1);

        // ADDI $4 then ADD $5,$4,$0 under a 5-cycle ex_stall
        do_reset();
        set_in(1, 1, 0, 1, 0, 2'b00, 0, 4, 0);
        tick();
        ex_stall = 1'b1;
        set_in(1, 1, 1, 1, 1, 2'b00, 4, 0, 5);
        for (int i = 0; i < 5; i++) begin
            check("stl_hazard", hazard, 1);
            check("stl_hold", id_hold, 1);
            check("stl_bubble", ex_bubble, 0);
            check("stl_count", stall_count, 0);
            tick();
        end
        ex_stall = 1'b0;
        #1;
        check("stl_r1_hazard", hazard, 1);
        check("stl_r1_bubble", ex_bubble, 1);
        tick();
        check("stl_r2_hazard", hazard, 1);
        tick();
        check("stl_r3_hazard", hazard, 0);
        check("stl_r3_count", stall_count, 2);

        // LW $5, flushed dependent, then a reader of $5 and $6
        do_reset();
        set_in(1, 1, 0, 1, 0, 2'b00, 0, 5, 0);
        tick();
        flush = 1'b1;
        set_in(1, 1, 0, 1, 1, 2'b00, 5, 0, 6);
        check("fl_hazard", hazard, 0);
        check("fl_bubble", ex_bubble, 1);
        check("fl_hold", id_hold, 0);
        tick();
        flush = 1'b0;
        set_in(1, 1, 1, 1, 1, 2'b00, 5, 6, 7);
        check("fl_next_c1_hazard", hazard, 1);
        tick();
        check("fl_next_c2_hazard", hazard, 0);
        check("fl_count", stall_count, 1);

        // Fill the scoreboard with a nonzero count, then reset mid-flight
        do_reset();
        set_in(1, 1, 0, 1, 0, 2'b00, 0, 1, 0);
        tick();
        set_in(1, 1, 1, 1, 1, 2'b00, 1, 1, 2);
        tick(); tick(); tick();
        set_in(1, 1, 0, 1, 0, 2'b00, 0, 3, 0);
        tick();
        set_in(1, 1, 0, 1, 0, 2'b00, 0, 4, 0);
        tick();
        set_in(1, 1, 0, 1, 1, 2'b00, 4, 0, 8);
        check("full_busy", busy, 1);
        check("full_hazard", hazard, 1);
        check("full_count", stall_count, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", stall_count, 0);
        check("mid_rst_hazard", hazard, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
